fibonacci_checker: RTL

FIBONACCI_CHECKER -- requirements
Module: fibonacci_checker

---
 rtl/fibonacci_checker.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fibonacci_checker.sv
// -----------------------------------------------------------------------------
// fibonacci_checker
//   Checks an incoming sample stream against the Fibonacci sequence
//   1, 1, 2, 3, 5, 8, ... (additions wrap modulo 2^DATA_WIDTH). It counts good
//   samples, asserts locked after LOCK_LEN good samples, and on the first
//   mismatch captures the index, the offending value and the expected value.
//   After a mismatch it stays failed until clear or reset.
//
// Ports
//   clk          : clock, rising edge
//   resetn       : synchronous active-low reset (priority over clear/in_valid)
//   clear        : synchronous restart; a sample in the same cycle is dropped
//   in_valid     : in_data holds a sample
//   in_data      : sample under test
//   in_ready     : checker accepts a sample this cycle (low only during clear)
//   match_count  : good samples since reset/clear, saturating
//   locked       : match_count >= LOCK_LEN and no error
//   err          : sticky mismatch flag
//   err_index    : 0-based index of the first bad sample
//   err_data     : value of the first bad sample
//   err_expected : value that was expected at err_index
// -----------------------------------------------------------------------------
module fibonacci_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int LOCK_LEN   = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [CNT_WIDTH-1:0]  match_count,
    output logic                  locked,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  err_index,
    output logic [DATA_WIDTH-1:0] err_data,
    output logic [DATA_WIDTH-1:0] err_expected
);

    typedef enum logic [1:0] {FIRST, SECOND, TRACK, FAIL} state_e;

    localparam logic [CNT_WIDTH-1:0]  LOCK_C = CNT_WIDTH'(LOCK_LEN);
    localparam logic [DATA_WIDTH-1:0] ONE    = DATA_WIDTH'(1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d, prev2_q, prev2_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, eidx_q, eidx_d;
    logic [DATA_WIDTH-1:0] edata_q, edata_d, eexp_q, eexp_d;
    logic                  err_q, err_d, locked_q, locked_d;
    logic [DATA_WIDTH-1:0] expected;
    logic                  accept;

    assign in_ready = ~clear;
    assign accept   = in_valid && in_ready;

    // FIRST/SECOND always expect 1; TRACK sums the history (carry dropped).
    assign expected = (state_q == TRACK) ? prev_q + prev2_q : ONE;

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        prev2_d  = prev2_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        eidx_d   = eidx_q;
        edata_d  = edata_q;
        eexp_d   = eexp_q;
        if (clear) begin
            state_d = FIRST;
            prev_d  = ONE;
            prev2_d = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            eidx_d  = '0;
            edata_d = '0;
            eexp_d  = '0;
        end else if (accept && state_q != FAIL) begin
            if (in_data == expected) begin
                case (state_q)
                    FIRST:   state_d = SECOND;
                    SECOND:  state_d = TRACK;
                    default: state_d = TRACK;
                endcase
                // Shifting in FIRST/SECOND too leaves prev=prev2=1 on entry
                // to TRACK, so the first TRACK expectation is 2.
                prev2_d = prev_q;
                prev_d  = in_data;
                cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end else begin
                state_d = FAIL;
                err_d   = 1'b1;
                eidx_d  = cnt_q;
                edata_d = in_data;
                eexp_d  = expected;
            end
        end
        locked_d = (state_d != FAIL) && (cnt_d >= LOCK_C);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= FIRST;
            prev_q   <= ONE;
            prev2_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            eidx_q   <= '0;
            edata_q  <= '0;
            eexp_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            prev2_q  <= prev2_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            eidx_q   <= eidx_d;
            edata_q  <= edata_d;
            eexp_q   <= eexp_d;
            locked_q <= locked_d;
        end
    end

    assign match_count  = cnt_q;
    assign locked       = locked_q;
    assign err          = err_q;
    assign err_index    = eidx_q;
    assign err_data     = edata_q;
    assign err_expected = eexp_q;

endmodule
